// File: rtl/multicycle_control_unit.sv
// Instruction-sequencing FSM for the multi-cycle 16-bit RISC core.
// Holds IR, walks FETCH/DECODE/EXEC/MEM/WB and drives register-file, ALU, memory and PC controls.
module multicycle_control_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_data,
  input  logic        mem_ready,
  input  logic        zero,
  output logic [2:0]  state,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_fetch,
  output logic        pc_wr,
  output logic [1:0]  pc_src,
  output logic [2:0]  addr1,
  output logic [2:0]  addr2,
  output logic [2:0]  addr3,
  output logic        RegWr,
  output logic        wb_sel,
  output logic [1:0]  alu_op,
  output logic        alu_src_b,
  output logic [15:0] imm,
  output logic        illegal,
  output logic        bus_error
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_ANDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t          st;
  logic [15:0]     ir;
  logic [CW-1:0]   wait_cnt;
  logic [3:0]      op;
  logic            is_rtype;
  logic            is_illegal;
  logic            timed_out;

  assign op         = ir[15:12];
  assign is_rtype   = (op == OP_AND) || (op == OP_ADD) || (op == OP_SUB);
  assign is_illegal = (op > OP_JMP);
  // Completion on the limit cycle wins over the timeout.
  assign timed_out  = (wait_cnt == LIMIT) && !mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= FETCH;
      ir       <= '0;
      wait_cnt <= '0;
    end else begin
      case (st)
        FETCH: begin
          if (mem_ready) begin
            ir       <= mem_data;
            st       <= DECODE;
            wait_cnt <= '0;
          end else if (timed_out) begin
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DECODE: st <= ((op == OP_JMP) || is_illegal) ? FETCH : EXEC;
        EXEC: begin
          if (op == OP_BEQ)                       st <= FETCH;
          else if ((op == OP_LW) || (op == OP_SW)) st <= MEM;
          else                                     st <= WB;
        end
        MEM: begin
          if (mem_ready) begin
            st       <= (op == OP_LW) ? WB : FETCH;
            wait_cnt <= '0;
          end else if (timed_out) begin
            st       <= FETCH;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        WB:      st <= FETCH;
        default: st <= FETCH;
      endcase
    end
  end

  // Moore decode of state and IR; only FETCH/BEQ pc_wr and the timeout look at inputs.
  always_comb begin
    state        = st;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    pc_wr        = 1'b0;
    pc_src       = 2'd0;
    RegWr        = 1'b0;
    wb_sel       = 1'b0;
    alu_op       = 2'd0;
    alu_src_b    = 1'b0;
    illegal      = 1'b0;
    bus_error    = 1'b0;
    addr1        = ir[8:6];
    addr2        = is_rtype ? ir[5:3] : ir[11:9];
    addr3        = ir[11:9];
    imm          = (op == OP_JMP) ? {4'd0, ir[11:0]} : {{10{ir[5]}}, ir[5:0]};
    case (st)
      FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        pc_wr        = mem_ready;
        bus_error    = timed_out;
      end
      DECODE: begin
        if (op == OP_JMP) begin
          pc_wr  = 1'b1;
          pc_src = 2'd2;
        end else if (is_illegal) begin
          illegal = 1'b1;
        end
      end
      EXEC: begin
        alu_src_b = (op >= OP_ADDI) && (op <= OP_SW);
        if ((op == OP_SUB) || (op == OP_BEQ))       alu_op = 2'd1;
        else if ((op == OP_AND) || (op == OP_ANDI)) alu_op = 2'd2;
        if (op == OP_BEQ) begin
          pc_src = 2'd1;
          pc_wr  = zero;
        end
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = (op == OP_SW);
        bus_error = timed_out;
      end
      WB: begin
        RegWr  = 1'b1;
        wb_sel = (op == OP_LW);
      end
      default: ;
    endcase
    // Reset forces a quiet bus so an aborted instruction never writes anything.
    if (reset) begin
      state        = 3'd0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_is_fetch = 1'b1;
      pc_wr        = 1'b0;
      pc_src       = 2'd0;
      RegWr        = 1'b0;
      wb_sel       = 1'b0;
      alu_op       = 2'd0;
      alu_src_b    = 1'b0;
      illegal      = 1'b0;
      bus_error    = 1'b0;
      addr1        = 3'd0;
      addr2        = 3'd0;
      addr3        = 3'd0;
      imm          = 16'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: each driven cycle queues its expected outputs,
// and a negedge monitor pops and compares them.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [2:0]  state;
    logic        mem_req;
    logic        mem_we;
    logic        mem_is_fetch;
    logic        pc_wr;
    logic [1:0]  pc_src;
    logic [2:0]  addr1;
    logic [2:0]  addr2;
    logic [2:0]  addr3;
    logic        regwr;
    logic        wb_sel;
    logic [1:0]  alu_op;
    logic        alu_src_b;
    logic [15:0] imm;
    logic        illegal;
    logic        bus_error;
  } out_t;

  logic        clk;
  logic        reset;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        zero;
  logic [2:0]  state;
  logic        mem_req, mem_we, mem_is_fetch, pc_wr;
  logic [1:0]  pc_src;
  logic [2:0]  addr1, addr2, addr3;
  logic        RegWr, wb_sel;
  logic [1:0]  alu_op;
  logic        alu_src_b;
  logic [15:0] imm;
  logic        illegal, bus_error;

  out_t  act;
  out_t  exp_q[$];
  string tag_q[$];
  out_t  mon_e;
  string mon_t;
  int    vectors = 0;
  int    miscompares = 0;

  multicycle_control_unit #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .mem_data(mem_data), .mem_ready(mem_ready), .zero(zero),
    .state(state), .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch),
    .pc_wr(pc_wr), .pc_src(pc_src), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .RegWr(RegWr), .wb_sel(wb_sel), .alu_op(alu_op), .alu_src_b(alu_src_b), .imm(imm),
    .illegal(illegal), .bus_error(bus_error)
  );

  assign act = '{state, mem_req, mem_we, mem_is_fetch, pc_wr, pc_src, addr1, addr2, addr3,
                 RegWr, wb_sel, alu_op, alu_src_b, imm, illegal, bus_error};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare against the oldest queued expectation in the middle of each cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      vectors++;
      if (act !== mon_e) begin
        miscompares++;
        $display("[TB] FAIL %s: got %h (state=%0d regwr=%b pc_wr=%b bus_error=%b) expected %h (state=%0d regwr=%b pc_wr=%b bus_error=%b)",
                 mon_t, act, act.state, act.regwr, act.pc_wr, act.bus_error,
                 mon_e, mon_e.state, mon_e.regwr, mon_e.pc_wr, mon_e.bus_error);
      end
    end
  end

  function automatic out_t base(input logic [2:0] st, input logic [2:0] a1, input logic [2:0] a2,
                                input logic [2:0] a3, input logic [15:0] im);
    out_t o;
    o = '0;
    o.state = st;
    o.addr1 = a1;
    o.addr2 = a2;
    o.addr3 = a3;
    o.imm   = im;
    return o;
  endfunction

  function automatic out_t fe(input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] a3,
                              input logic [15:0] im, input logic pcw, input logic berr);
    out_t o;
    o = base(3'd0, a1, a2, a3, im);
    o.mem_req      = 1'b1;
    o.mem_is_fetch = 1'b1;
    o.pc_wr        = pcw;
    o.bus_error    = berr;
    return o;
  endfunction

  function automatic out_t rstv();
    out_t o;
    o = '0;
    o.mem_is_fetch = 1'b1;
    return o;
  endfunction

  task automatic applyStimulus(input logic rst, input logic [15:0] data, input logic rdy,
                               input logic z, input out_t e, input string t);
    reset     = rst;
    mem_data  = data;
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  out_t e;

  initial begin
    reset = 1'b1; mem_data = 16'h0; mem_ready = 1'b0; zero = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h0, 1'b0, 1'b0, rstv(), "reset");

    // ADD r3,r1,r2
    applyStimulus(1'b0, 16'h1650, 1'b1, 1'b0, fe(3'd0, 3'd0, 3'd0, 16'h0, 1'b1, 1'b0), "add fetch");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, base(3'd1, 3'd1, 3'd2, 3'd3, 16'h0010), "add decode");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, base(3'd2, 3'd1, 3'd2, 3'd3, 16'h0010), "add exec");
    e = base(3'd4, 3'd1, 3'd2, 3'd3, 16'h0010); e.regwr = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, e, "add wb");

    // LW r4,2(r1) with two MEM wait cycles
    applyStimulus(1'b0, 16'h5842, 1'b1, 1'b0, fe(3'd1, 3'd2, 3'd3, 16'h0010, 1'b1, 1'b0), "lw fetch");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, base(3'd1, 3'd1, 3'd4, 3'd4, 16'h0002), "lw decode");
    e = base(3'd2, 3'd1, 3'd4, 3'd4, 16'h0002); e.alu_src_b = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, e, "lw exec");
    e = base(3'd3, 3'd1, 3'd4, 3'd4, 16'h0002); e.mem_req = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, e, "lw mem wait1");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, e, "lw mem wait2");
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, e, "lw mem done");
    e = base(3'd4, 3'd1, 3'd4, 3'd4, 16'h0002); e.regwr = 1'b1; e.wb_sel = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, e, "lw wb");

    // BEQ r1,r1,-2 taken then not taken
    applyStimulus(1'b0, 16'h727E, 1'b1, 1'b0, fe(3'd1, 3'd4, 3'd4, 16'h0002, 1'b1, 1'b0), "beq1 fetch");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, base(3'd1, 3'd1, 3'd1, 3'd1, 16'hFFFE), "beq1 decode");
    e = base(3'd2, 3'd1, 3'd1, 3'd1, 16'hFFFE); e.alu_op = 2'd1; e.pc_src = 2'd1; e.pc_wr = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, e, "beq taken exec");
    applyStimulus(1'b0, 16'h727E, 1'b1, 1'b0, fe(3'd1, 3'd1, 3'd1, 16'hFFFE, 1'b1, 1'b0), "beq2 fetch");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, base(3'd1, 3'd1, 3'd1, 3'd1, 16'hFFFE), "beq2 decode");
    e = base(3'd2, 3'd1, 3'd1, 3'd1, 16'hFFFE); e.alu_op = 2'd1; e.pc_src = 2'd1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, e, "beq not taken exec");

    // Illegal opcode 0xF, then JMP 0x123
    applyStimulus(1'b0, 16'hF000, 1'b1, 1'b0, fe(3'd1, 3'd1, 3'd1, 16'hFFFE, 1'b1, 1'b0), "illegal fetch");
    e = base(3'd1, 3'd0, 3'd0, 3'd0, 16'h0000); e.illegal = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, e, "illegal decode");
    applyStimulus(1'b0, 16'h8123, 1'b1, 1'b0, fe(3'd0, 3'd0, 3'd0, 16'h0, 1'b1, 1'b0), "jmp fetch");
    e = base(3'd1, 3'd4, 3'd0, 3'd0, 16'h0123); e.pc_wr = 1'b1; e.pc_src = 2'd2;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, e, "jmp decode");

    // FETCH timeout: bus_error on the 16th waiting cycle
    for (int i = 0; i < 15; i++)
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, fe(3'd4, 3'd0, 3'd0, 16'h0123, 1'b0, 1'b0), "fetch wait");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, fe(3'd4, 3'd0, 3'd0, 16'h0123, 1'b0, 1'b1), "fetch timeout");

    // Ready arriving on the limit cycle completes without bus_error (ADD r5,r1,r2)
    for (int i = 0; i < 15; i++)
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, fe(3'd4, 3'd0, 3'd0, 16'h0123, 1'b0, 1'b0), "fetch wait2");
    applyStimulus(1'b0, 16'h1A50, 1'b1, 1'b0, fe(3'd4, 3'd0, 3'd0, 16'h0123, 1'b1, 1'b0), "fetch limit ready");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, base(3'd1, 3'd1, 3'd2, 3'd5, 16'h0010), "add5 decode");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, base(3'd2, 3'd1, 3'd2, 3'd5, 16'h0010), "add5 exec");

    // Reset during WB suppresses RegWr and returns to FETCH with IR cleared
    applyStimulus(1'b1, 16'h0, 1'b0, 1'b0, rstv(), "add5 wb under reset");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, fe(3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0), "post-reset fetch");

    // SW r2,1(r3) with MEM timeout: mem_we held, bus_error on 16th MEM cycle, IR kept
    applyStimulus(1'b0, 16'h64C1, 1'b1, 1'b0, fe(3'd0, 3'd0, 3'd0, 16'h0, 1'b1, 1'b0), "sw fetch");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, base(3'd1, 3'd3, 3'd2, 3'd2, 16'h0001), "sw decode");
    e = base(3'd2, 3'd3, 3'd2, 3'd2, 16'h0001); e.alu_src_b = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, e, "sw exec");
    e = base(3'd3, 3'd3, 3'd2, 3'd2, 16'h0001); e.mem_req = 1'b1; e.mem_we = 1'b1;
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, e, "sw mem wait");
    e.bus_error = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, e, "sw mem timeout");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, fe(3'd3, 3'd2, 3'd2, 16'h0001, 1'b0, 1'b0), "after mem timeout");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
